// File: rtl/iprf_write_arbiter.sv
// iprf_write_arbiter: per-requester writeback FIFOs drained round-robin onto PORT_NUM regfile write ports.
module iprf_write_arbiter #(
    parameter int REQ_NUM   = 6,
    parameter int PORT_NUM  = 4,
    parameter int BUF_DEPTH = 2,
    parameter int XLEN      = 64,
    parameter int IPR_W     = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [REQ_NUM-1:0]                   i_wb_vld,
    input  logic [REQ_NUM-1:0][IPR_W-1:0]        i_wb_iprIdx,
    input  logic [REQ_NUM-1:0][XLEN-1:0]         i_wb_data,
    output logic [REQ_NUM-1:0]                   o_wb_stall,
    output logic [PORT_NUM-1:0]                  o_write_vld,
    output logic [PORT_NUM-1:0][IPR_W-1:0]       o_write_iprIdx,
    output logic [PORT_NUM-1:0][XLEN-1:0]        o_write_data,
    output logic                                 o_pending
);
    localparam int RW = REQ_NUM > 1 ? $clog2(REQ_NUM) : 1;
    localparam int HW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int NW = $clog2(PORT_NUM + 1);

    typedef struct packed {
        logic [IPR_W-1:0] idx;
        logic [XLEN-1:0]  data;
    } ent_t;

    ent_t          mem_q  [REQ_NUM][BUF_DEPTH];
    logic [HW-1:0] head_q [REQ_NUM];
    logic [HW-1:0] head_d [REQ_NUM];
    logic [HW-1:0] tail_q [REQ_NUM];
    logic [HW-1:0] tail_d [REQ_NUM];
    logic [CW-1:0] cnt_q  [REQ_NUM];
    logic [CW-1:0] cnt_d  [REQ_NUM];
    logic [RW-1:0] rr_q, rr_d;
    logic [REQ_NUM-1:0] enq, grant, nonempty;
    logic [RW:0]   scan;
    logic [RW-1:0] sel;
    logic [NW-1:0] n;

    always_comb begin
        for (int j = 0; j < REQ_NUM; j++) begin
            nonempty[j]   = cnt_q[j] != '0;
            o_wb_stall[j] = cnt_q[j] >= CW'(BUF_DEPTH - 1);
            // Index 0 is the hardwired zero register; full FIFOs drop the request.
            enq[j]        = i_wb_vld[j] && |i_wb_iprIdx[j] && cnt_q[j] != CW'(BUF_DEPTH);
            head_d[j]     = grant[j] ? head_q[j] + 1'b1 : head_q[j];
            tail_d[j]     = enq[j] ? tail_q[j] + 1'b1 : tail_q[j];
            cnt_d[j]      = cnt_q[j] + CW'(enq[j]) - CW'(grant[j]);
        end
        o_pending = |nonempty;
    end

    // Circular scan from rr; the k-th non-empty FIFO found lands on port k.
    always_comb begin
        grant          = '0;
        o_write_vld    = '0;
        o_write_iprIdx = '0;
        o_write_data   = '0;
        n              = '0;
        scan           = '0;
        sel            = '0;
        rr_d           = rr_q;
        for (int k = 0; k < REQ_NUM; k++) begin
            scan = (RW+1)'(rr_q) + (RW+1)'(k);
            sel  = scan >= (RW+1)'(REQ_NUM) ? RW'(scan - (RW+1)'(REQ_NUM)) : RW'(scan);
            if (nonempty[sel] && n < NW'(PORT_NUM)) begin
                grant[sel] = 1'b1;
                for (int p = 0; p < PORT_NUM; p++) begin
                    if (n == NW'(p)) begin
                        o_write_vld[p]    = 1'b1;
                        o_write_iprIdx[p] = mem_q[sel][head_q[sel]].idx;
                        o_write_data[p]   = mem_q[sel][head_q[sel]].data;
                    end
                end
                n    = n + 1'b1;
                rr_d = sel == RW'(REQ_NUM - 1) ? '0 : sel + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
            for (int j = 0; j < REQ_NUM; j++) begin
                head_q[j] <= '0;
                tail_q[j] <= '0;
                cnt_q[j]  <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int j = 0; j < REQ_NUM; j++) begin
                head_q[j] <= head_d[j];
                tail_q[j] <= tail_d[j];
                cnt_q[j]  <= cnt_d[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < REQ_NUM; j++) begin
            if (enq[j]) mem_q[j][tail_q[j]] <= {i_wb_iprIdx[j], i_wb_data[j]};
        end
    end

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_ovf
        assert property (@(posedge clk) disable iff (!rst)
            !(i_wb_vld[g] && cnt_q[g] == CW'(BUF_DEPTH)));
    end
endmodule

// File: tb/tb_iprf_write_arbiter.sv
// tb_iprf_write_arbiter: directed and randomized traffic checked against a queue-based reference model.
module tb_iprf_write_arbiter;
    localparam int RQ = 6;
    localparam int PN = 4;
    localparam int BD = 2;
    localparam int XL = 32;
    localparam int IW = 6;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [XL-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [RQ-1:0]         vld;
    logic [RQ-1:0][IW-1:0] idx;
    logic [RQ-1:0][XL-1:0] dat;
    logic [RQ-1:0]         stall;
    logic [PN-1:0]         wr_vld;
    logic [PN-1:0][IW-1:0] wr_idx;
    logic [PN-1:0][XL-1:0] wr_data;
    logic                  pending;

    ent_t q[RQ][$];
    int rr = 0;
    int passed = 0;
    int total = 0;
    int wr_obs = 0;
    int acc_total = 0;
    logic [RQ-1:0] last_stall = '0;

    always #5 clk = ~clk;

    iprf_write_arbiter #(.REQ_NUM(RQ), .PORT_NUM(PN), .BUF_DEPTH(BD), .XLEN(XL), .IPR_W(IW)) dut (
        .clk(clk), .rst(rst),
        .i_wb_vld(vld), .i_wb_iprIdx(idx), .i_wb_data(dat),
        .o_wb_stall(stall), .o_write_vld(wr_vld), .o_write_iprIdx(wr_idx),
        .o_write_data(wr_data), .o_pending(pending)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        vld = '0;
        idx = '0;
        dat = '0;
    endtask

    task automatic drive(input int i, input logic [IW-1:0] ix, input logic [XL-1:0] d);
        vld[i] = 1'b1;
        idx[i] = ix;
        dat[i] = d;
    endtask

    // Compare the current cycle against the model, then advance the model across one edge.
    task automatic step();
        logic [PN-1:0]         ev;
        logic [PN-1:0][IW-1:0] ei;
        logic [PN-1:0][XL-1:0] ed;
        logic [RQ-1:0]         es, gr, acc;
        logic                  ep;
        int cnt, last, r;
        ev = '0; ei = '0; ed = '0; gr = '0; es = '0; ep = 1'b0; cnt = 0; last = -1;
        for (int k = 0; k < RQ; k++) begin
            r = (rr + k) % RQ;
            if (q[r].size() > 0 && cnt < PN) begin
                ev[cnt] = 1'b1;
                ei[cnt] = q[r][0].idx;
                ed[cnt] = q[r][0].data;
                gr[r]   = 1'b1;
                cnt++;
                last = r;
            end
        end
        for (int i = 0; i < RQ; i++) begin
            es[i] = q[i].size() >= BD - 1;
            ep    = ep | (q[i].size() > 0);
        end
        chk("write_vld", wr_vld, ev);
        chk("write_idx", wr_idx, ei);
        chk("write_data", wr_data, ed);
        chk("wb_stall", stall, es);
        chk("pending", pending, ep);
        wr_obs += $countones(wr_vld);
        last_stall = es;
        @(posedge clk);
        for (int i = 0; i < RQ; i++) acc[i] = rst && vld[i] && idx[i] != '0 && q[i].size() < BD;
        for (int i = 0; i < RQ; i++) begin
            if (gr[i]) void'(q[i].pop_front());
            if (acc[i]) begin
                q[i].push_back({idx[i], dat[i]});
                acc_total++;
            end
        end
        if (last >= 0) rr = (last + 1) % RQ;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        repeat (2) @(negedge clk);
        chk("rst_vld", wr_vld, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pending", pending, 0);
        rst = 1'b1;

        // single writeback, one cycle latency to port 0
        drive(2, 6'd5, 32'hAB);
        step();
        idle();
        chk("single_vld", wr_vld, 4'b0001);
        chk("single_idx", wr_idx[0], 5);
        chk("single_data", wr_data[0], 32'hAB);
        step();

        // move rr to 0, then all six at once
        drive(5, 6'd3, 32'h55);
        step();
        idle();
        step();
        for (int i = 0; i < RQ; i++) drive(i, IW'(10 + i), XL'(32'h100 + i));
        step();
        idle();
        chk("all6_c1_vld", wr_vld, 4'b1111);
        for (int p = 0; p < PN; p++) chk("all6_c1_idx", wr_idx[p], 10 + p);
        step();
        chk("all6_c2_vld", wr_vld, 4'b0011);
        chk("all6_c2_idx0", wr_idx[0], 14);
        chk("all6_c2_idx1", wr_idx[1], 15);
        step();

        // back-to-back on one requester keeps order
        drive(1, 6'd7, 32'h11);
        step();
        drive(1, 6'd8, 32'h22);
        chk("b2b_stall", stall[1], 1);
        step();
        idle();
        chk("b2b_idx", wr_idx[0], 8);
        step();
        chk("b2b_unstall", stall[1], 0);

        // writes to register 0 vanish
        drive(3, 6'd0, 32'hFF);
        step();
        idle();
        chk("zero_pending", pending, 0);
        chk("zero_vld", wr_vld, 0);
        step();

        // sustained traffic honoring stall, then random traffic
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < RQ; i++) begin
                if (!last_stall[i] && (c < 100 || $urandom_range(0, 3) != 0))
                    drive(i, ($urandom_range(0, 7) == 0) ? IW'(0) : IW'($urandom_range(1, 63)), XL'($urandom));
                else begin
                    vld[i] = 1'b0;
                    idx[i] = '0;
                end
            end
            step();
        end
        idle();
        repeat (6) step();
        chk("drain_pending", pending, 0);
        chk("no_loss_dup", wr_obs, acc_total);

        // reset in the middle of buffered traffic
        for (int i = 0; i < RQ; i++) drive(i, IW'(20 + i), XL'($urandom));
        step();
        step();
        idle();
        #2 rst = 1'b0;
        #1;
        chk("midrst_vld", wr_vld, 0);
        chk("midrst_stall", stall, 0);
        chk("midrst_pending", pending, 0);
        for (int i = 0; i < RQ; i++) q[i].delete();
        rr = 0;
        @(negedge clk);
        step();
        step();
        #2 rst = 1'b1;
        step();
        drive(4, 6'd9, 32'h99);
        step();
        idle();
        chk("post_rst_vld", wr_vld, 4'b0001);
        chk("post_rst_idx", wr_idx[0], 9);
        chk("post_rst_data", wr_data[0], 32'h99);
        step();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/iprf_write_arbiter.md
IPRF_WRITE_ARBITER -- requirements
Module: iprf_write_arbiter

Interface
REQ-001 SHALL have parameter REQ_NUM, default 6, number of FU writeback requesters.
REQ-002 SHALL have parameter PORT_NUM, default 4, number of physical int regfile write ports (PORT_NUM <= REQ_NUM).
REQ-003 SHALL have parameter BUF_DEPTH, default 2, per-requester writeback buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1, single clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_wb_vld, input, REQ_NUM, per-requester writeback valid (fu_finished && rd_wen).
REQ-007 SHALL have port i_wb_iprIdx, input, iprIdx_t[REQ_NUM], destination physical register.
REQ-008 SHALL have port i_wb_data, input, XLEN[REQ_NUM], result data.
REQ-009 SHALL have port o_wb_stall, output, REQ_NUM, requester i must not present i_wb_vld next cycle while set.
REQ-010 SHALL have port o_write_vld, output, PORT_NUM, regfile write enable per port.
REQ-011 SHALL have port o_write_iprIdx, output, iprIdx_t[PORT_NUM], regfile write index.
REQ-012 SHALL have port o_write_data, output, XLEN[PORT_NUM], regfile write data.
REQ-013 SHALL have port o_pending, output, 1, any buffer non-empty.

Function
REQ-014 SHALL keep one FIFO per requester (BUF_DEPTH entries, head/tail pointers wrapping modulo BUF_DEPTH, occupancy counter 0..BUF_DEPTH).
REQ-015 SHALL enqueue {iprIdx,data} into FIFO i on a clk edge where i_wb_vld[i]=1 and i_wb_iprIdx[i]!=0; writes to iprIdx 0 are discarded.
REQ-016 SHALL present write ports combinationally from FIFO heads; minimum latency enqueue edge -> port visible = 1 cycle, regfile commits at the following edge.
REQ-017 SHALL grant up to PORT_NUM non-empty FIFOs per cycle, scanning requesters circularly starting at round-robin pointer rr.
REQ-018 SHALL assign granted heads to ports 0,1,2... in scan order; unused ports drive o_write_vld=0, iprIdx=0, data=0.
REQ-019 SHALL dequeue every granted head at the clock edge ending the grant cycle.
REQ-020 SHALL update rr to (last granted index + 1) mod REQ_NUM when at least one grant; rr unchanged when none.
REQ-021 SHALL drive o_wb_stall[i] = (occupancy_i >= BUF_DEPTH-1), from registered occupancy only, so one in-flight request always fits.
REQ-022 SHALL handle simultaneous enqueue and dequeue on the same FIFO: occupancy unchanged, both pointers advance.
REQ-023 SHALL, for enqueue into an empty FIFO, not write the port in the same cycle (no bypass).
REQ-024 SHALL never grant the same requester on two ports in one cycle; one head per FIFO per cycle.
REQ-025 SHALL flag (simulation assertion) i_wb_vld[i]=1 while occupancy_i == BUF_DEPTH; the request is dropped, state unchanged.
REQ-026 SHALL preserve per-requester order; no ordering guarantee across requesters.
REQ-027 SHALL drive o_pending = OR of all (occupancy != 0).

Reset
REQ-028 SHALL, while rst=0, clear all FIFO pointers and occupancy, set rr=0, drive o_write_vld=0, o_wb_stall=0, o_pending=0, asynchronously.
REQ-029 SHALL discard any buffered writeback when reset asserts mid-operation; no port write occurs until a new enqueue after rst deasserts.
REQ-030 SHALL accept i_wb_vld on the first rising edge after rst deasserts.

Verification (REQ_NUM=6, PORT_NUM=4, BUF_DEPTH=2)
REQ-031 SHALL cover: single i_wb_vld[2]=1 idx=5 data=0xAB at edge 0 -> cycle 1 port0 vld idx=5 data=0xAB, ports1-3 vld=0, rr=3 after edge 1.
REQ-032 SHALL cover: all 6 valid at edge 0, rr=0 -> cycle 1 ports0-3 = req0..3; cycle 2 ports0-1 = req4,5; rr=4 then 0.
REQ-033 SHALL cover: req1 valid two consecutive edges with others idle -> stall[1]=1 after first enqueue only if occupancy reaches 1 and not drained; verify occupancy never exceeds 2 and order preserved.
REQ-034 SHALL cover: write with iprIdx=0 -> no enqueue, o_pending stays 0, no port write.
REQ-035 SHALL cover: 6 FIFOs full-ish, rst pulsed low mid-cycle -> all outputs 0 immediately, no write after release until new request.
REQ-036 SHALL cover: sustained all-6 traffic 100 cycles honoring stall -> every requester granted within 2 cycles of reaching head, no loss, no duplicate.
